// File: rtl/dsc_mul_param_if.sv
// Operand/result bundle for the stochastic multiplier.
// Handshake: an operation is accepted on a rising edge where start=1 while busy=0;
// done pulses for exactly one cycle with z valid, and z holds until the next acceptance.
interface dsc_mul_param_if #(parameter int WIDTH = 6);
  logic               start;
  logic               mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] z;
  logic               sa;
  logic               sb;
  logic               sy;
  logic [1:0]         state;

  modport master (
    output start, mode, a, b,
    input  busy, done, z, sa, sb, sy, state
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, z, sa, sb, sy, state
  );
endinterface

// File: rtl/dsc_mul_param.sv
// Deterministic stochastic-computing multiplier: counter/comparator SNGs in
// clock-division order, AND of the two unary streams, product counted back to binary.
module dsc_mul_param #(
  parameter int WIDTH = 6
) (
  input logic            clk,
  input logic            rst,
  dsc_mul_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   MAX_W = '1;
  localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]     ONE_W1 = {{WIDTH{1'b0}}, 1'b1};

  state_t               state;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 mode_q;
  logic [WIDTH-1:0]     cnt_a;
  logic [WIDTH-1:0]     cnt_b;
  logic [2*WIDTH-1:0]   z_q;
  logic                 busy_q;
  logic                 done_q;

  logic sa;
  logic sb;
  logic sy;
  logic row_end;
  logic last;

  // Early termination stops once B's run of ones is exhausted; later rows add nothing.
  always_comb begin
    sa      = (state == RUN) && (cnt_a < a_q);
    sb      = (state == RUN) && (cnt_b < b_q);
    sy      = sa & sb;
    row_end = (cnt_a == MAX_W);
    last    = row_end &&
              ((cnt_b == MAX_W) ||
               (mode_q && (({1'b0, cnt_b} + ONE_W1) >= {1'b0, b_q})));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      z_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mode_q <= bus.mode;
            cnt_a  <= '0;
            cnt_b  <= '0;
            z_q    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          z_q   <= z_q + {{(2*WIDTH-1){1'b0}}, sy};
          cnt_a <= cnt_a + ONE_W;
          if (row_end) begin
            cnt_b <= cnt_b + ONE_W;
          end
          if (last) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.z     = z_q;
  assign bus.sa    = sa;
  assign bus.sb    = sb;
  assign bus.sy    = sy;
  assign bus.state = state;

endmodule

// File: tb/tb_dsc_mul_param.sv
// Bench for dsc_mul_param at WIDTH 4, 5 and 6: directed cases plus random
// operations checked against a product / run-length reference model.
module tb_dsc_mul_param;

  logic clk;
  logic rst;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       start_v;
  logic       mode_v;
  logic [5:0] a_v;
  logic [5:0] b_v;
  int         sel;

  dsc_mul_param_if #(.WIDTH(4)) if4 ();
  dsc_mul_param_if #(.WIDTH(5)) if5 ();
  dsc_mul_param_if #(.WIDTH(6)) if6 ();

  dsc_mul_param #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  dsc_mul_param #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));
  dsc_mul_param #(.WIDTH(6)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));

  assign if4.start = start_v && (sel == 4);
  assign if4.mode  = mode_v;
  assign if4.a     = a_v[3:0];
  assign if4.b     = b_v[3:0];
  assign if5.start = start_v && (sel == 5);
  assign if5.mode  = mode_v;
  assign if5.a     = a_v[4:0];
  assign if5.b     = b_v[4:0];
  assign if6.start = start_v && (sel == 6);
  assign if6.mode  = mode_v;
  assign if6.a     = a_v;
  assign if6.b     = b_v;

  logic        busy_o;
  logic        done_o;
  logic [11:0] z_o;
  logic        sa_o;
  logic        sb_o;
  logic        sy_o;

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    z_o    = '0;
    sa_o   = 1'b0;
    sb_o   = 1'b0;
    sy_o   = 1'b0;
    case (sel)
      4: begin
        busy_o = if4.busy; done_o = if4.done; z_o = {4'b0, if4.z};
        sa_o = if4.sa; sb_o = if4.sb; sy_o = if4.sy;
      end
      5: begin
        busy_o = if5.busy; done_o = if5.done; z_o = {2'b0, if5.z};
        sa_o = if5.sa; sb_o = if5.sb; sy_o = if5.sy;
      end
      default: begin
        busy_o = if6.busy; done_o = if6.done; z_o = if6.z;
        sa_o = if6.sa; sb_o = if6.sb; sy_o = if6.sy;
      end
    endcase
  end

  // scoreboard
  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: unary streams multiply exactly, run length from the termination rule
  function automatic int ref_len(input int w, input int b, input bit m);
    if (m) return ((b == 0) ? 1 : b) << w;
    return 1 << (2 * w);
  endfunction

  // driver tasks
  task automatic launch(input int w, input int a, input int b, input bit m, input bit hold);
    @(negedge clk);
    sel     = w;
    a_v     = 6'(a);
    b_v     = 6'(b);
    mode_v  = m;
    start_v = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v = 1'b0;
    check("busy_after_accept", 32'(busy_o), 32'd1);
    exp_q.push_back(32'(a * b));
  endtask

  // Counts edges from the acceptance edge until done, tallying product-stream ones.
  task automatic wait_done(input int exp_n, input string tag, input bit perturb, input bit hold);
    int cycles;
    int ones;
    int limit;
    logic [31:0] exp_z;
    cycles = 0;
    ones   = 0;
    limit  = exp_n + 20;
    exp_z  = exp_q.pop_front();
    while (1) begin
      if (!done_o) ones += int'(sy_o);
      @(posedge clk);
      #1;
      cycles++;
      if (perturb && cycles == 3) begin
        a_v     = 6'($urandom);
        b_v     = 6'($urandom);
        mode_v  = 1'($urandom);
        start_v = 1'b1;
      end
      if (perturb && cycles == 4) start_v = 1'b0;
      if (done_o || cycles >= limit) break;
    end
    check({tag, "_len"}, 32'(cycles), 32'(exp_n));
    check({tag, "_z"}, 32'(z_o), exp_z);
    check({tag, "_sy_count"}, 32'(ones), exp_z);
    check({tag, "_busy_with_done"}, 32'(busy_o), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy_o), 32'd0);
    check({tag, "_z_hold"}, 32'(z_o), exp_z);
    if (hold) begin
      @(posedge clk);
      #1;
      check({tag, "_reaccept"}, 32'(busy_o), 32'd1);
    end
  endtask

  task automatic do_op(input int w, input int a, input int b, input bit m, input string tag);
    launch(w, a, b, m, 1'b0);
    wait_done(ref_len(w, b, m), tag, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    sel     = 4;
    start_v = 1'b0;
    mode_v  = 1'b0;
    a_v     = '0;
    b_v     = '0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_z", 32'(z_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_streams", 32'({sa_o, sb_o, sy_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed W=4
    do_op(4, 3, 5, 1'b0, "w4_m0_3x5");
    do_op(4, 3, 5, 1'b1, "w4_m1_3x5");
    do_op(4, 15, 15, 1'b1, "w4_m1_15x15");
    do_op(4, 9, 0, 1'b1, "w4_m1_b0");

    // directed W=6
    do_op(6, 63, 63, 1'b0, "w6_m0_63x63");
    do_op(6, 0, 63, 1'b0, "w6_m0_0x63");
    do_op(6, 1, 1, 1'b0, "w6_m0_1x1");

    // start held high: re-accepted every N+2 cycles
    launch(4, 6, 7, 1'b1, 1'b1);
    wait_done(ref_len(4, 7, 1'b1), "hold1", 1'b0, 1'b1);
    start_v = 1'b0;
    exp_q.push_back(32'(6 * 7));
    wait_done(ref_len(4, 7, 1'b1), "hold2", 1'b0, 1'b0);

    // start pulses and operand changes mid-run are ignored
    launch(5, 11, 13, 1'b1, 1'b0);
    wait_done(ref_len(5, 13, 1'b1), "perturb", 1'b1, 1'b0);

    // asynchronous reset mid-run
    launch(4, 9, 9, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_z", 32'(z_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_streams", 32'({sa_o, sb_o, sy_o}), 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    do_op(4, 7, 2, 1'b1, "after_rst_7x2");

    // randomised operations with idle gaps
    for (int i = 0; i < 24; i++) begin
      int w;
      int a;
      int b;
      bit m;
      int gap;
      w = (i % 2 == 0) ? 4 : 5;
      a = int'($urandom_range((1 << w) - 1, 0));
      b = int'($urandom_range((1 << w) - 1, 0));
      m = 1'($urandom_range(1, 0));
      do_op(w, a, b, m, "rand");
      gap = int'($urandom_range(3, 0));
      repeat (gap) @(posedge clk);
      #1;
      check("rand_idle_hold", 32'(z_o), 32'(a * b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
